// File: rtl/medidor_frequencia.sv
// Period meter: synchronizes a strobe, detects rising edges and measures the
// spacing between them in clk cycles, with range flagging and a stall timeout.
module medidor_frequencia #(
  parameter int CNT_W      = 32,
  parameter int MIN_PERIOD = 4,
  parameter int MAX_PERIOD = 2**24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             too_fast,
  output logic             timeout,
  output logic [15:0]      edge_count,
  output logic             armed
);

  localparam logic [CNT_W-1:0] MinCnt = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] OneCnt = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt;
  logic             e;

  assign e = s2 & ~s3;

  // Synchronizer, measurement FSM and all outputs; pulses default low every cycle
  // and a dropped enable takes priority over anything the FSM would do.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      too_fast     <= 1'b0;
      timeout      <= 1'b0;
      edge_count   <= '0;
      armed        <= 1'b0;
    end else begin
      s1           <= sig_in;
      s2           <= s1;
      s3           <= s2;
      period_valid <= 1'b0;
      too_fast     <= 1'b0;
      timeout      <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        armed <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            armed <= 1'b0;
            state <= ARM;
          end
          ARM: begin
            if (e) begin
              cnt        <= OneCnt;
              edge_count <= edge_count + 16'd1;
              armed      <= 1'b1;
              state      <= MEASURE;
            end
          end
          MEASURE: begin
            // An edge arriving exactly at the limit is still a legal period.
            if (e) begin
              period       <= cnt;
              period_valid <= 1'b1;
              too_fast     <= (cnt < MinCnt);
              cnt          <= OneCnt;
              edge_count   <= edge_count + 16'd1;
            end else if (cnt >= MaxCnt) begin
              timeout <= 1'b1;
              cnt     <= '0;
              armed   <= 1'b0;
              state   <= ARM;
            end else begin
              cnt <= cnt + OneCnt;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            armed <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
